// File: rtl/bridge_egress_arb.sv
// bridge_egress_arb
//   Packet-atomic round-robin arbiter sharing one GMII egress port among
//   NUM_REQ ingress packet streams. A grant is taken in IDLE, held for a
//   whole packet in XFER, and followed by an IFG-cycle GAP before the next
//   arbitration.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | no grant; arbitrate among c_srdy starting at rr_ptr
//   XFER  | grant holder gnt connected straight through to egress
//   GAP   | inter-frame gap after EOP, all handshakes held off
//
// Ports
//   clk     : clock
//   reset   : synchronous reset, active low
//   c_srdy  : per-requester word valid
//   c_drdy  : per-requester word accept
//   c_data  : packed requester data, requester i at [i*WIDTH +: WIDTH]
//   c_eop   : per-requester end-of-packet, qualified by c_srdy
//   p_srdy  : egress word valid
//   p_drdy  : egress accept
//   p_data  : egress data
//   p_eop   : egress end-of-packet
//   p_src   : index of current grant holder
//   busy    : high in XFER or GAP

module bridge_egress_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IFG     = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          c_srdy,
  output logic [NUM_REQ-1:0]          c_drdy,
  input  logic [NUM_REQ*WIDTH-1:0]    c_data,
  input  logic [NUM_REQ-1:0]          c_eop,
  output logic                        p_srdy,
  input  logic                        p_drdy,
  output logic [WIDTH-1:0]            p_data,
  output logic                        p_eop,
  output logic [$clog2(NUM_REQ)-1:0]  p_src,
  output logic                        busy
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int GW = (IFG > 0) ? $clog2(IFG + 1) : 1;
  localparam int GAP_LOAD_I = (IFG > 0) ? IFG - 1 : 0;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_LOAD_I);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   gnt_q, gnt_d;
  logic [SW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

  logic            req_any;
  logic [SW-1:0]   win;
  logic [SW-1:0]   win_next;

  // Round-robin search: first requester with c_srdy set, starting at rr_ptr.
  // Only consulted in IDLE, so it never reaches an output combinationally.
  always_comb begin
    int            cand;
    int            win_i;
    logic [SW-1:0] cand_idx;
    req_any  = 1'b0;
    win_i    = 0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = SW'(cand);
      if (!req_any && c_srdy[cand_idx]) begin
        req_any = 1'b1;
        win_i   = cand;
      end
    end
    win      = SW'(win_i);
    win_next = (win_i + 1 >= NUM_REQ) ? '0 : SW'(win_i + 1);
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    c_drdy    = '0;
    p_srdy    = 1'b0;
    p_data    = '0;
    p_eop     = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d  = ST_XFER;
          gnt_d    = win;
          rr_ptr_d = win_next;
        end
      end
      ST_XFER: begin
        busy          = 1'b1;
        p_srdy        = c_srdy[gnt_q];
        p_data        = c_data[gnt_q*WIDTH +: WIDTH];
        p_eop         = c_eop[gnt_q];
        c_drdy[gnt_q] = p_drdy;
        if (c_srdy[gnt_q] && p_drdy && c_eop[gnt_q]) begin
          if (IFG == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Hold every handshake off while reset is asserted so that no word is
    // accepted in the cycle where the partial packet is being abandoned.
    if (!reset) begin
      c_drdy = '0;
      p_srdy = 1'b0;
      p_data = '0;
      p_eop  = 1'b0;
      busy   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      rr_ptr_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign p_src = gnt_q;

endmodule
